// File: rtl/alu_mult_seq_if.sv
// Command/response handshake bundle for alu_mult_seq.
// The master issues operands and takes results; the slave (the multiplier) answers.
interface alu_mult_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_ovf;

  modport master (
    output cmd_valid, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_ovf
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_ovf
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative 16x16 unsigned shift-and-add multiplier that borrows the 16-bit ALU for every add and shift.
// Optional macro MULT_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module alu_mult_seq #(
  parameter logic [2:0] OP_ADD = 3'b100,
  parameter logic [2:0] OP_SLL = 3'b001
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_mult_seq_if.slave        bus,
  output logic [15:0]          alu_a_o,
  output logic [15:0]          alu_b_o,
  output logic [2:0]           alu_op_o,
  output logic                 alu_cin_o,
  output logic                 alu_inva_o,
  output logic                 alu_invb_o,
  output logic                 alu_sign_o,
  input  logic [15:0]          alu_out_i,
  input  logic                 alu_ofl_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SHL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [15:0] mplier_shr_s;

  assign mplier_shr_s = {1'b0, mplier_q[15:1]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next state and datapath update, consuming the ALU's same-cycle response.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          acc_d    = 16'd0;
          mcand_d  = bus.cmd_a;
          mplier_d = bus.cmd_b;
          count_d  = 4'd0;
          ovf_d    = 1'b0;
`ifdef MULT_EARLY_TERM_EN
          if (bus.cmd_b == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
`else
          state_d  = S_ADD;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        if (mplier_q[0]) begin
          acc_d = alu_out_i;
          ovf_d = ovf_q | alu_ofl_i;
        end else begin
          acc_d = acc_q;
          ovf_d = ovf_q;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d  = alu_out_i;
        mplier_d = mplier_shr_s;
        // A set top bit shifted out only matters if a later add would still use it.
        if (mcand_q[15] && (mplier_shr_s != 16'd0)) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (count_q == 4'd15) begin
          state_d = S_DONE;
        end
`ifdef MULT_EARLY_TERM_EN
        else if (mplier_shr_s == 16'd0) begin
          state_d = S_DONE;
        end
`endif
        else begin
          count_d = count_q + 4'd1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_a_o       = 16'd0;
    alu_b_o       = 16'd0;
    alu_op_o      = OP_ADD;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      S_ADD: begin
        alu_a_o  = acc_q;
        alu_b_o  = mcand_q;
        alu_op_o = OP_ADD;
      end
      S_SHL: begin
        alu_a_o  = mcand_q;
        alu_b_o  = 16'd1;
        alu_op_o = OP_SLL;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
      end
      default: begin
        bus.cmd_ready = 1'b0;
      end
    endcase
  end

  assign bus.rsp_result = acc_q;
  assign bus.rsp_ovf    = ovf_q;
  assign alu_cin_o      = 1'b0;
  assign alu_inva_o     = 1'b0;
  assign alu_invb_o     = 1'b0;
  assign alu_sign_o     = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural ALU (add with carry, shift left) beside it.
module tb_alu_mult_seq;
  logic        clk;
  logic        rst;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl;
  int          pass_cnt;
  int          total_cnt;

  alu_mult_seq_if bus ();

  alu_mult_seq dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_op_o   (alu_op),
    .alu_cin_o  (alu_cin),
    .alu_inva_o (alu_inva),
    .alu_invb_o (alu_invb),
    .alu_sign_o (alu_sign),
    .alu_out_i  (alu_out),
    .alu_ofl_i  (alu_ofl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    alu_out = 16'd0;
    alu_ofl = 1'b0;
    case (alu_op)
      3'b100:  {alu_ofl, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_out = alu_a << alu_b[3:0];
      default: alu_out = 16'd0;
    endcase
  end

  // Edges after the accept edge until rsp_valid; a zero multiplier in the early-exit build is valid straight off the accept edge.
  function automatic int exp_lat(input logic [15:0] b);
    int hi;
    int n;
    hi = -1;
    for (int i = 0; i < 16; i++) if (b[i]) hi = i;
    n = 32;
`ifdef MULT_EARLY_TERM_EN
    n = (hi < 0) ? 0 : 2 * (hi + 1);
`else
    if (hi > 15) n = 0;
`endif
    return n;
  endfunction

  task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic ovf, output int lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 16'hDEAD;
    bus.cmd_b     = 16'hBEEF;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = bus.rsp_result;
    ovf = bus.rsp_ovf;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 16'd0;
    bus.cmd_b = 16'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      $display("FAIL reset_rsp: got rdy=%b vld=%b res=%h ovf=%b expected 1 0 0000 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf);
    end else pass_cnt++;
    total_cnt++;
    if ({alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign} !== {16'd0, 16'd0, 3'b100, 4'b0000}) begin
      $display("FAIL reset_alu: got A=%h B=%h op=%b ctl=%b%b%b%b expected 0000 0000 100 0000",
               alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign);
    end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_products();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [15:0] vr [6];
    logic        vo [6];
    logic [15:0] res;
    logic        ovf;
    int          lat;
    va = '{16'h0003, 16'h00FF, 16'hFFFF, 16'h0100, 16'h1234, 16'h0000};
    vb = '{16'h0005, 16'h0101, 16'hFFFF, 16'h0100, 16'h0000, 16'h1234};
    vr = '{16'h000F, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      run_mult(va[k], vb[k], res, ovf, lat);
      total_cnt++;
      if (res !== vr[k]) $display("FAIL product_%0d: got %h expected %h", k, res, vr[k]);
      else pass_cnt++;
      total_cnt++;
      if (ovf !== vo[k]) $display("FAIL ovf_%0d: got %b expected %b", k, ovf, vo[k]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== exp_lat(vb[k])) $display("FAIL latency_%0d: got %0d expected %0d", k, lat, exp_lat(vb[k]));
      else pass_cnt++;
      take_rsp();
      total_cnt++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
        $display("FAIL handshake_%0d: got vld=%b rdy=%b expected 0 1", k, bus.rsp_valid, bus.cmd_ready);
      end else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    logic        ovf;
    int          lat;
    run_mult(16'h0007, 16'h0003, res, ovf, lat);
    total_cnt++;
    if ({res, ovf} !== {16'h0015, 1'b0}) $display("FAIL bp_result: got %h/%b expected 0015/0", res, ovf);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, bus.cmd_ready, alu_op, alu_a, alu_b} !==
          {1'b1, 16'h0015, 1'b0, 1'b0, 3'b100, 16'd0, 16'd0}) begin
        $display("FAIL bp_hold_%0d: got vld=%b res=%h ovf=%b rdy=%b op=%b A=%h B=%h expected 1 0015 0 0 100 0000 0000",
                 c, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, bus.cmd_ready, alu_op, alu_a, alu_b);
      end else pass_cnt++;
    end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    logic        ovf;
    int          lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 16'h0007;
    bus.cmd_b = 16'h0009;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, alu_op, alu_a, alu_b} !==
        {1'b1, 1'b0, 16'd0, 1'b0, 3'b100, 16'd0, 16'd0}) begin
      $display("FAIL mid_reset: got rdy=%b vld=%b res=%h ovf=%b op=%b A=%h B=%h expected 1 0 0000 0 100 0000 0000",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, alu_op, alu_a, alu_b);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    total_cnt++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      $display("FAIL mid_reset_idle: got vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.cmd_ready);
    end else pass_cnt++;
    run_mult(16'h0007, 16'h0009, res, ovf, lat);
    total_cnt++;
    if ({res, ovf} !== {16'h003F, 1'b0}) $display("FAIL after_reset: got %h/%b expected 003F/0", res, ovf);
    else pass_cnt++;
    total_cnt++;
    if (lat !== exp_lat(16'h0009)) $display("FAIL after_reset_lat: got %0d expected %0d", lat, exp_lat(16'h0009));
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 16'h0002;
    bus.cmd_b = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_a = 16'h0004;
    bus.cmd_b = 16'h0005;
    total_cnt++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL b2b_busy_ready: got %b expected 0", bus.cmd_ready);
    else pass_cnt++;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_result, bus.cmd_ready} !== {1'b1, 16'h0006, 1'b0}) begin
      $display("FAIL b2b_first: got vld=%b res=%h rdy=%b expected 1 0006 0", bus.rsp_valid, bus.rsp_result, bus.cmd_ready);
    end else pass_cnt++;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      $display("FAIL b2b_idle_gap: got vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.cmd_ready);
    end else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    total_cnt++;
    if ({bus.rsp_result, bus.rsp_ovf} !== {16'h0014, 1'b0}) begin
      $display("FAIL b2b_second: got %h/%b expected 0014/0", bus.rsp_result, bus.rsp_ovf);
    end else pass_cnt++;
    total_cnt++;
    if (lat !== exp_lat(16'h0005)) $display("FAIL b2b_second_lat: got %0d expected %0d", lat, exp_lat(16'h0005));
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_single_valid: got %b expected 0", bus.rsp_valid);
    else pass_cnt++;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_products();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
